switch_allocator: RTL
=====================

# switch_allocator

Per-output wormhole switch allocator for the 5-port router (L=0, N=1, E=2, S=3, W=4). It takes per-input routing requests, arbitrates each output port round-robin, holds an output for a whole packet from head to tail, and drives the crossbar `Select_*` lines plus per-input pop strobes. It sits between the input buffers/route computation and the crossbar.

## Interface
- No parameters. Port index encoding is fixed: 0=L, 1=N, 2=E, 3=S, 4=W. Select code 3'd7 means idle, and the crossbar then outputs 0.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous reset, active-high.
- `Req` input [4:0]: bit i is high when input i has a flit at its buffer head.
- `Dest` input [14:0]: `Dest[3i+2:3i]` is the requested output of input i. It is stable for the whole packet. Values 5–7 are invalid.
- `Tail` input [4:0]: bit i is high when the head flit of input i is a tail. A single-flit packet has `Tail` high on its only flit.
- `Ready` input [4:0]: bit o is high when downstream of output o can accept a flit this cycle.
- `Grant` output [4:0]: bit i pops one flit from input i this cycle.
- `Out_Valid` output [4:0]: bit o means output o carries a valid flit this cycle.
- `Select_L`, `Select_N`, `Select_E`, `Select_S`, `Select_W` output [2:0]: crossbar selects, one per output.

## Operation
- Each output o has a state machine with two states, IDLE and LOCKED. Each output also has an owner register `own_o` [2:0] and a round-robin pointer `ptr_o` [2:0] with range 0..4.
- Input i is **eligible** for output o when all of the following hold:
  - `Req[i]` is 1.
  - `Dest_i` equals o.
  - input i is not the owner of any LOCKED output.
- IDLE → LOCKED happens at the clock edge when output o is IDLE, `Ready[o]` is 1, and at least one input is eligible.
  - The winner is the first eligible input found searching `ptr_o`, `ptr_o`+1, … mod 5.
  - On this edge: `own_o` ← winner and `ptr_o` ← (winner+1) mod 5.
  - No flit moves in the allocation cycle.
- In LOCKED:
  - `Select_o` = `own_o`.
  - `Grant[own_o]` = `Out_Valid[o]` = `Req[own_o] & Ready[o]`. This logic is combinational.
- LOCKED → IDLE happens at the edge where `Grant[own_o]` and `Tail[own_o]` are both 1.
  - `Select_o` returns to 7 in the next cycle.
  - The output can be re-allocated at that same next edge at the earliest.
- In IDLE: `Select_o` = 7 and `Out_Valid[o]` = 0.
- `Ready[o]` low while LOCKED:
  - No grant is issued and the lock is held.
  - Flow resumes in the cycle `Ready[o]` returns high.
- `Req[own_o]` low mid-packet (a bubble): no grant is issued and the lock is held.
- An invalid `Dest` (5–7) is never eligible. It produces no grant and no error.
- A U-turn (input i to output i) is legal.
- Simultaneous events:
  - Several outputs may allocate on the same edge, to distinct inputs.
  - One input is eligible for only one output, since `Dest` is single-valued.
- Ownership is one-to-one: at most one `Grant` bit per input and at most one owner per output.

## Timing
- Reset values:
  - All outputs IDLE.
  - All `Select_*` = 3'd7.
  - `Grant` = 0 and `Out_Valid` = 0.
  - All `ptr_o` = 0 and all `own_o` = 0.
- Reset mid-packet drops all locks at that edge. Outputs show the reset values in the following cycle.
- Head-flit latency: 1 cycle from `Req` high (with `Ready` high) to first `Grant`.
- Body and tail throughput: 1 flit per cycle per output while `Req` and `Ready` are high.
- Minimum packet occupancy: 2 cycles for a single-flit packet (1 allocation cycle + 1 transfer cycle).
- Back-to-back packets on one output: there is ≥1 idle cycle between the tail grant and the next head grant.
- `Grant`, `Out_Valid` and `Select_*` depend combinationally on registered state and on the current `Req`/`Ready`. There are no combinational paths from `Dest` or `Tail` to the outputs.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → all `Select_*` = 7, `Grant` = 0, `Out_Valid` = 0.
- **Single 3-flit packet L→E:**
  - Stimulus: `Req[0]` = 1, `Dest_0` = 2, `Ready` = 5'h1F, `Tail[0]` high on the 3rd flit.
  - Cycle 0: no grant.
  - Cycles 1–3: `Select_E` = 0, `Grant` = 5'b00001, `Out_Valid[2]` = 1.
  - Cycle 4: `Select_E` = 7.
- **Round-robin contention:**
  - Stimulus: inputs N, S and W all request output L with single-flit packets, held continuously.
  - Required grant order: N(1), S(3), W(4), then N again.
  - Each packet takes 2 cycles, with `ptr_L` advancing past each winner.
- **Backpressure:**
  - Stimulus: a locked 4-flit packet W→N; `Ready[1]` = 0 for cycles 2–3.
  - Required response: no `Grant[4]` in those cycles, `Select_N` stays 4, and all 4 flits are delivered once `Ready[1]` returns.
- **Parallel and illegal requests:**
  - L→S and E→W allocated in the same cycle → both grant concurrently.
  - Input N with `Dest` = 6 → never granted.
- **Reset mid-packet:**
  - Stimulus: assert `rst` during flit 2 of a 5-flit packet L→N.
  - Required response: next cycle `Select_N` = 7; after reset, a new request from L re-allocates with the 1-cycle latency.

Source files
------------

// File: rtl/switch_allocator.sv
// switch_allocator: per-output wormhole switch allocator for a 5-port router
// (0=L, 1=N, 2=E, 3=S, 4=W). Each output is allocated round-robin among
// eligible inputs, is held from head to tail, and drives a crossbar select.
// Select code 7 means idle.
module switch_allocator (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Req,
  input  logic [14:0] Dest,
  input  logic [4:0]  Tail,
  input  logic [4:0]  Ready,
  output logic [4:0]  Grant,
  output logic [4:0]  Out_Valid,
  output logic [2:0]  Select_L,
  output logic [2:0]  Select_N,
  output logic [2:0]  Select_E,
  output logic [2:0]  Select_S,
  output logic [2:0]  Select_W
);

  localparam int         NP       = 5;
  localparam logic [2:0] SEL_IDLE = 3'd7;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state_q [NP];
  state_t     state_d [NP];
  logic [2:0] own_q   [NP];
  logic [2:0] own_d   [NP];
  logic [2:0] ptr_q   [NP];
  logic [2:0] ptr_d   [NP];

  logic [NP-1:0] busy;
  logic [NP-1:0] elig [NP];
  logic [NP-1:0] own_tail;
  logic [2:0]    sel  [NP];

  // Round-robin pointer increment over the range 0..4.
  function automatic logic [2:0] inc5(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // Inputs that currently own a locked output cannot compete elsewhere.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    busy = '0;
    for (int o = 0; o < NP; o++)
      for (int i = 0; i < NP; i++)
        if (state_q[o] == LOCKED && own_q[o] == 3'(i))
          busy[i] = 1'b1;
  end

  // Eligibility matrix: elig[o][i] when input i requests output o and is free.
  // Invalid destinations 5..7 never match any output.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      elig[o] = '0;
      for (int i = 0; i < NP; i++)
        elig[o][i] = Req[i] && (Dest[3*i +: 3] == 3'(o)) && !busy[i];
    end
  end

  // Crossbar selects, grants and valids from locked state and live Req/Ready.
  always_comb begin
    Grant     = '0;
    Out_Valid = '0;
    own_tail  = '0;
    for (int o = 0; o < NP; o++) begin
      sel[o] = SEL_IDLE;
      if (state_q[o] == LOCKED) begin
        sel[o] = own_q[o];
        for (int i = 0; i < NP; i++) begin
          if (own_q[o] == 3'(i)) begin
            own_tail[o] = Tail[i];
            if (Req[i] && Ready[o]) begin
              Grant[i]     = 1'b1;
              Out_Valid[o] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Per-output next state: allocate round-robin from IDLE, release on tail grant.
  always_comb begin
    logic       found;
    logic [2:0] cand;
    logic [2:0] win;
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    cand    = 3'd0;
    win     = 3'd0;
    for (int o = 0; o < NP; o++) begin
      found = 1'b0;
      cand  = ptr_q[o];
      win   = 3'd0;
      for (int k = 0; k < NP; k++) begin
        if (!found && elig[o][cand]) begin
          found = 1'b1;
          win   = cand;
        end
        cand = inc5(cand);
      end
      case (state_q[o])
        IDLE: begin
          if (Ready[o] && found) begin
            state_d[o] = LOCKED;
            own_d[o]   = win;
            ptr_d[o]   = inc5(win);
          end
        end
        LOCKED: begin
          if (Out_Valid[o] && own_tail[o])
            state_d[o] = IDLE;
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  // State, owner and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: owner and pointer arrays are tiny control state, so they are reset explicitly like the FSMs.
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= IDLE;
        own_q[o]   <= 3'd0;
        ptr_q[o]   <= 3'd0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Select_L = sel[0];
  assign Select_N = sel[1];
  assign Select_E = sel[2];
  assign Select_S = sel[3];
  assign Select_W = sel[4];

endmodule
